ysyx_220053_mdu: RTL and testbench

YSYX_220053_MDU -- requirements
Module: ysyx_220053_mdu

---
 rtl/ysyx_220053_mdu.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx_220053_mdu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220053_mdu.sv
// RV64M multiply/divide unit: iterative radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a one-cycle sign/select fix-up.
module ysyx_220053_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  op,
    input  logic [63:0] inputa,
    input  logic [63:0] inputb,
    input  logic        mwb_block,
    output logic        alu_busy,
    output logic        res_valid,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state;
    logic [3:0]     op_r;
    logic [5:0]     cnt;
    logic [63:0]    opnd;
    logic [127:0]   acc;
    logic           neg_a;
    logic           neg_b;
    logic           special;
    logic [63:0]    spec_res;

    function automatic logic is_w_op(input logic [3:0] o);
        return o[3] && (o <= 4'd12);
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        return ((o >= 4'd4) && (o <= 4'd7)) || ((o >= 4'd9) && (o <= 4'd12));
    endfunction

    function automatic logic is_rem_op(input logic [3:0] o);
        return (o == 4'd6) || (o == 4'd7) || (o == 4'd11) || (o == 4'd12);
    endfunction

    function automatic logic signed_a_op(input logic [3:0] o);
        return (o == 4'd1) || (o == 4'd2) || (o == 4'd4) || (o == 4'd6) ||
               (o == 4'd9) || (o == 4'd11);
    endfunction

    function automatic logic signed_b_op(input logic [3:0] o);
        return (o == 4'd1) || (o == 4'd4) || (o == 4'd6) || (o == 4'd9) || (o == 4'd11);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Request decode: operands are widened to 64 bits so one datapath serves W ops.
    logic           w_in;
    logic           div_in;
    logic           rem_in;
    logic [63:0]    wide_a;
    logic [63:0]    wide_b;
    logic [63:0]    zero_a;
    logic [63:0]    zero_b;
    logic           neg_a_in;
    logic           neg_b_in;
    logic [63:0]    mag_a;
    logic [63:0]    mag_b;
    logic           b_zero;
    logic           ovf;
    logic           reserved;
    logic           special_in;
    logic [63:0]    spec_val;

    always_comb begin
        w_in       = is_w_op(op);
        div_in     = is_div_op(op);
        rem_in     = is_rem_op(op);
        wide_a     = w_in ? sext32(inputa[31:0]) : inputa;
        wide_b     = w_in ? sext32(inputb[31:0]) : inputb;
        zero_a     = w_in ? {32'd0, inputa[31:0]} : inputa;
        zero_b     = w_in ? {32'd0, inputb[31:0]} : inputb;
        neg_a_in   = signed_a_op(op) && wide_a[63];
        neg_b_in   = signed_b_op(op) && wide_b[63];
        mag_a      = neg_a_in ? (64'd0 - wide_a) : zero_a;
        mag_b      = neg_b_in ? (64'd0 - wide_b) : zero_b;
        b_zero     = (zero_b == 64'd0);
        ovf        = div_in && signed_b_op(op) && (wide_b == '1) &&
                     (wide_a == (w_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        reserved   = (op >= 4'd13);
        special_in = reserved || (div_in && (b_zero || ovf));
        if (reserved)
            spec_val = 64'd0;
        else if (b_zero)
            spec_val = rem_in ? wide_a : '1;
        else
            spec_val = rem_in ? 64'd0 : wide_a;
    end

    // One iteration step for each algorithm; acc holds {hi, lo} of the working pair.
    logic [64:0]    mul_sum;
    logic [127:0]   mul_next;
    logic [64:0]    rem_sh;
    logic [64:0]    rem_sub;
    logic           ge;
    logic [127:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, opnd} : 65'd0);
        mul_next = {mul_sum, acc[63:1]};
        rem_sh   = {acc[127:64], acc[63]};
        rem_sub  = rem_sh - {1'b0, opnd};
        ge       = (rem_sh >= {1'b0, opnd});
        div_next = {ge ? rem_sub[63:0] : rem_sh[63:0], acc[62:0], ge};
    end

    // Sign correction and result selection; W multiplies land at acc[95:32].
    logic           w_r;
    logic [127:0]   prod;
    logic [127:0]   prod_s;
    logic [63:0]    quot;
    logic [63:0]    quot_s;
    logic [63:0]    rem_s;
    logic [63:0]    fix_res;

    always_comb begin
        w_r    = is_w_op(op_r);
        prod   = w_r ? {64'd0, acc[95:32]} : acc;
        prod_s = (neg_a ^ neg_b) ? (128'd0 - prod) : prod;
        quot   = w_r ? {32'd0, acc[31:0]} : acc[63:0];
        quot_s = (neg_a ^ neg_b) ? (64'd0 - quot) : quot;
        rem_s  = neg_a ? (64'd0 - acc[127:64]) : acc[127:64];
        case (op_r)
            4'd0:                fix_res = prod_s[63:0];
            4'd1, 4'd2, 4'd3:    fix_res = prod_s[127:64];
            4'd4, 4'd5:          fix_res = quot_s;
            4'd6, 4'd7:          fix_res = rem_s;
            4'd8:                fix_res = sext32(prod_s[31:0]);
            4'd9, 4'd10:         fix_res = sext32(quot_s[31:0]);
            4'd11, 4'd12:        fix_res = sext32(rem_s[31:0]);
            default:             fix_res = 64'd0;
        endcase
        if (special)
            fix_res = spec_res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            alu_busy  <= 1'b0;
            res_valid <= 1'b0;
            result    <= 64'd0;
            cnt       <= 6'd0;
            op_r      <= 4'd0;
            opnd      <= 64'd0;
            acc       <= 128'd0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            special   <= 1'b0;
            spec_res  <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_r     <= op;
                        neg_a    <= neg_a_in;
                        neg_b    <= neg_b_in;
                        special  <= special_in;
                        spec_res <= spec_val;
                        alu_busy <= 1'b1;
                        if (special_in) begin
                            state <= FIX;
                        end else begin
                            state <= CALC;
                            cnt   <= w_in ? 6'd31 : 6'd63;
                            // Divide: dividend is left-aligned so its MSB is consumed first.
                            if (div_in) begin
                                opnd <= mag_b;
                                acc  <= {64'd0, w_in ? {mag_a[31:0], 32'd0} : mag_a};
                            end else begin
                                opnd <= mag_a;
                                acc  <= {64'd0, mag_b};
                            end
                        end
                    end
                end
                CALC: begin
                    acc <= is_div_op(op_r) ? div_next : mul_next;
                    if (cnt == 6'd0)
                        state <= FIX;
                    else
                        cnt <= cnt - 6'd1;
                end
                FIX: begin
                    result    <= fix_res;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (!mwb_block) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        alu_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220053_mdu.sv
// Bench for ysyx_220053_mdu: arithmetic reference model plus per-cycle
// protocol model, directed corner cases and randomized operations.
module tb_ysyx_220053_mdu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [3:0]  op;
    logic [63:0] inputa;
    logic [63:0] inputb;
    logic        mwb_block;
    logic        alu_busy;
    logic        res_valid;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    ysyx_220053_mdu dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .op        (op),
        .inputa    (inputa),
        .inputb    (inputb),
        .mwb_block (mwb_block),
        .alu_busy  (alu_busy),
        .res_valid (res_valid),
        .result    (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural result of one operation, straight from the RV64M rules.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  r;
        longint       sa;
        longint       sb;
        int           sa32;
        int           sb32;
        logic [31:0]  ua;
        logic [31:0]  ub;
        logic         ovf32;
        sa = a; sb = b;
        ua = a[31:0]; ub = b[31:0];
        sa32 = ua; sb32 = ub;
        ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
        r = 64'd0;
        case (o)
            4'd0: r = a * b;
            4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
            4'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            4'd4: if (b == 0) r = '1; else if (a == MIN64 && b == '1) r = a; else r = 64'(sa / sb);
            4'd5: if (b == 0) r = '1; else r = a / b;
            4'd6: if (b == 0) r = a; else if (a == MIN64 && b == '1) r = 0; else r = 64'(sa % sb);
            4'd7: if (b == 0) r = a; else r = a % b;
            4'd8: r = sx(ua * ub);
            4'd9: if (ub == 0) r = '1; else if (ovf32) r = sx(ua); else r = sx(32'(sa32 / sb32));
            4'd10: if (ub == 0) r = '1; else r = sx(ua / ub);
            4'd11: if (ub == 0) r = sx(ua); else if (ovf32) r = 64'd0; else r = sx(32'(sa32 % sb32));
            4'd12: if (ub == 0) r = sx(ua); else r = sx(ua % ub);
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Edges from accept (counted as edge 1) to the edge that raises res_valid.
    function automatic int exp_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic w;
        logic dv;
        logic bz;
        logic ov;
        w  = (o >= 4'd8) && (o <= 4'd12);
        dv = (o inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12});
        bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ov = (o inside {4'd4, 4'd6, 4'd9, 4'd11}) &&
             (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == '1));
        if (o >= 4'd13 || (dv && (bz || ov)))
            return 2;
        return w ? 34 : 66;
    endfunction

    // Protocol model: busy from accept until release, valid after the latency, result held.
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_result <= 64'd0;
            m_left   <= 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_left <= exp_lat(op, inputa, inputb) - 1;
                m_pend <= model(op, inputa, inputb);
            end
        end else if (!m_valid) begin
            if (m_left == 1) begin
                m_valid  <= 1'b1;
                m_result <= m_pend;
            end
            m_left <= m_left - 1;
        end else if (!mwb_block) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check1("mon_busy", alu_busy, m_busy);
        check1("mon_valid", res_valid, m_valid);
        check64("mon_result", result, m_result);
    end

    task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input logic use_lit, input logic [63:0] lit, input int hold);
        int          edges;
        int          want_lat;
        logic [63:0] want;
        want     = model(o, a, b);
        want_lat = (lat < 0) ? exp_lat(o, a, b) : lat;
        op = o; inputa = a; inputb = b;
        req_valid = 1'b1;
        mwb_block = (hold > 0);
        @(posedge clk); #1;
        edges = 1;
        req_valid = 1'b0;
        while (!res_valid && edges < 100) begin
            req_valid = ($urandom % 4 == 0);
            op = 4'($urandom);
            inputa = {$urandom, $urandom};
            inputb = {$urandom, $urandom};
            @(posedge clk); #1;
            edges++;
        end
        req_valid = 1'b0;
        check_int($sformatf("latency_op%0d", o), edges, want_lat);
        check64($sformatf("result_op%0d", o), result, want);
        if (use_lit)
            check64($sformatf("literal_op%0d", o), result, lit);
        repeat (hold) begin
            req_valid = ($urandom % 2 == 0);
            @(posedge clk); #1;
            check1("hold_valid", res_valid, 1'b1);
            check64("hold_result", result, want);
        end
        mwb_block = 1'b0;
        req_valid = 1'b1;
        op = 4'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check1("release_busy", alu_busy, 1'b0);
        check1("release_valid", res_valid, 1'b0);
    endtask

    function automatic logic [63:0] rnd_opnd();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = {$urandom, $urandom};
            1: v = 64'd0;
            2: v = '1;
            3: v = MIN64;
            4: v = 64'($urandom_range(0, 40)) - 64'd20;
            default: v = {$urandom, 32'h8000_0000};
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b0;
        req_valid = 1'b0;
        op = 4'd0;
        inputa = 64'd0;
        inputb = 64'd0;
        mwb_block = 1'b0;
        #12;
        check1("reset_busy", alu_busy, 1'b0);
        check1("reset_valid", res_valid, 1'b0);
        check64("reset_result", result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op(4'd3, '1, '1, 66, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op(4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 34, 1'b1, '1, 0);
        run_op(4'd4, 64'd5, 64'd0, 2, 1'b1, '1, 0);
        run_op(4'd4, MIN64, '1, 2, 1'b1, MIN64, 0);
        run_op(4'd6, MIN64, '1, 2, 1'b1, 64'd0, 0);
        run_op(4'd10, 64'h1_8000_0000, 64'd1, 34, 1'b1, 64'hFFFF_FFFF_8000_0000, 0);
        run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 66, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 5);
        run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 66, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op(4'd13, 64'd9, 64'd9, 2, 1'b1, 64'd0, 0);
        run_op(4'd1, '1, '1, 66, 1'b1, 64'd0, 0);
        run_op(4'd2, '1, 64'd2, 66, 1'b1, '1, 0);
        run_op(4'd9, 64'h8000_0000, 64'hFFFF_FFFF, 2, 1'b1, 64'hFFFF_FFFF_8000_0000, 0);
        run_op(4'd12, 64'd10, 64'd0, 2, 1'b1, 64'd10, 2);

        // Abort a divide mid-iteration with reset, then issue a fresh request.
        op = 4'd4; inputa = 64'd1000; inputb = 64'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check1("abort_busy", alu_busy, 1'b0);
        check1("abort_valid", res_valid, 1'b0);
        check64("abort_result", result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(4'd5, 64'd100, 64'd7, 66, 1'b1, 64'd14, 0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  o;
            logic [63:0] a;
            logic [63:0] b;
            o = 4'($urandom_range(0, 15));
            a = rnd_opnd();
            b = rnd_opnd();
            run_op(o, a, b, -1, 1'b0, 64'd0, $urandom_range(0, 3));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
